// File: rtl/dcache_arbiter_pkg.sv
// Shared types for the data-cache port arbiter: FSM state encoding and the
// registered request payload driven toward the D-cache.
package dcache_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned MASK_W = DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        STORE = 2'd2,
        DRAIN = 2'd3
    } dcache_arb_state_t;

    typedef struct packed {
        logic              read;
        logic              write;
        logic [ADDR_W-1:0] address;
        logic [DATA_W-1:0] wdata;
        logic [MASK_W-1:0] byte_enable;
    } dcache_req_t;

endpackage

// File: rtl/dcache_arbiter.sv
// Shares the single D-cache port between committed stores and speculative loads,
// holding each request stable until the cache responds and draining flushed loads.
module dcache_arbiter
    import dcache_arbiter_pkg::*;
#(
    parameter int unsigned STORE_STREAK_MAX = 4,
    parameter int unsigned STREAK_W         = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              st_req,
    input  logic [ADDR_W-1:0] st_addr,
    input  logic [DATA_W-1:0] st_wdata,
    input  logic [MASK_W-1:0] st_byte_enable,
    output logic              st_resp,
    input  logic              ld_req,
    input  logic [ADDR_W-1:0] ld_addr,
    output logic              ld_resp,
    output logic [DATA_W-1:0] ld_rdata,
    output logic              mem_read_d,
    output logic              mem_write_d,
    output logic [ADDR_W-1:0] mem_address_d,
    output logic [DATA_W-1:0] mem_wdata_d,
    output logic [MASK_W-1:0] mem_byte_enable_d,
    input  logic              mem_resp_d,
    input  logic [DATA_W-1:0] mem_rdata_d
);

    dcache_arb_state_t   state_q, state_d;
    logic [STREAK_W-1:0] streak_q, streak_d;
    dcache_req_t         req_q, req_d;

    logic ld_req_eff;
    logic grant_st;
    logic grant_ld;
    logic streak_open;

    // A flushed load must not win arbitration in the flush cycle itself.
    assign ld_req_eff  = ld_req & ~flush;
    assign streak_open = 32'(streak_q) < STORE_STREAK_MAX;
    assign grant_st    = st_req & (~ld_req_eff | streak_open);
    assign grant_ld    = ~grant_st & ld_req_eff;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (grant_st) begin
                    state_d = STORE;
                end else if (grant_ld) begin
                    state_d = LOAD;
                end
            end
            STORE: begin
                if (mem_resp_d) begin
                    state_d = IDLE;
                end
            end
            LOAD: begin
                if (mem_resp_d) begin
                    state_d = IDLE;
                end else if (flush) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_resp_d) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Response strobes plus next values of the held cache request and store streak.
    always_comb begin
        st_resp  = 1'b0;
        ld_resp  = 1'b0;
        req_d    = req_q;
        streak_d = streak_q;
        case (state_q)
            IDLE: begin
                if (grant_st) begin
                    req_d = '{read:        1'b0,
                              write:       1'b1,
                              address:     st_addr,
                              wdata:       st_wdata,
                              byte_enable: st_byte_enable};
                    if (ld_req_eff) begin
                        streak_d = (streak_q == '1) ? streak_q : streak_q + STREAK_W'(1);
                    end else begin
                        streak_d = '0;
                    end
                end else if (grant_ld) begin
                    req_d = '{read:        1'b1,
                              write:       1'b0,
                              address:     ld_addr,
                              wdata:       '0,
                              byte_enable: '0};
                    streak_d = '0;
                end
            end
            STORE: begin
                if (mem_resp_d) begin
                    st_resp     = 1'b1;
                    req_d.write = 1'b0;
                end
            end
            LOAD: begin
                if (mem_resp_d) begin
                    ld_resp    = ~flush;
                    req_d.read = 1'b0;
                end
            end
            DRAIN: begin
                if (mem_resp_d) begin
                    req_d.read = 1'b0;
                end
            end
            default: begin
                req_d.read  = 1'b0;
                req_d.write = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            req_q    <= '0;
            streak_q <= '0;
        end else begin
            req_q    <= req_d;
            streak_q <= streak_d;
        end
    end

    assign mem_read_d        = req_q.read;
    assign mem_write_d       = req_q.write;
    assign mem_address_d     = req_q.address;
    assign mem_wdata_d       = req_q.wdata;
    assign mem_byte_enable_d = req_q.byte_enable;
    assign ld_rdata          = mem_rdata_d;

    a_rw_exclusive: assert property (@(posedge clk) disable iff (!rst)
        !(mem_read_d && mem_write_d));

    a_no_resp_in_idle: assert property (@(posedge clk) disable iff (!rst)
        !(state_q == IDLE && mem_resp_d));

endmodule

// File: tb/tb_dcache_arbiter.sv
// Directed scenarios followed by a randomized run checked against a
// transaction-level model of the store/load arbitration rules.
module tb_dcache_arbiter;
    import dcache_arbiter_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        st_req;
    logic [31:0] st_addr;
    logic [31:0] st_wdata;
    logic [3:0]  st_byte_enable;
    logic        st_resp;
    logic        ld_req;
    logic [31:0] ld_addr;
    logic        ld_resp;
    logic [31:0] ld_rdata;
    logic        mem_read_d;
    logic        mem_write_d;
    logic [31:0] mem_address_d;
    logic [31:0] mem_wdata_d;
    logic [3:0]  mem_byte_enable_d;
    logic        mem_resp_d;
    logic [31:0] mem_rdata_d;

    int errors = 0;
    int checks = 0;

    dcache_arbiter dut (
        .clk               (clk),
        .rst               (rst),
        .flush             (flush),
        .st_req            (st_req),
        .st_addr           (st_addr),
        .st_wdata          (st_wdata),
        .st_byte_enable    (st_byte_enable),
        .st_resp           (st_resp),
        .ld_req            (ld_req),
        .ld_addr           (ld_addr),
        .ld_resp           (ld_resp),
        .ld_rdata          (ld_rdata),
        .mem_read_d        (mem_read_d),
        .mem_write_d       (mem_write_d),
        .mem_address_d     (mem_address_d),
        .mem_wdata_d       (mem_wdata_d),
        .mem_byte_enable_d (mem_byte_enable_d),
        .mem_resp_d        (mem_resp_d),
        .mem_rdata_d       (mem_rdata_d)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    // randomized-phase model state
    int          act;       // 0 none, 1 load, 2 store
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_be;
    logic        m_cancel;
    int          m_wait;
    int          m_streak;
    logic        sp, lp, ld_eff;
    logic [31:0] sa, sd, la, rd;
    logic [3:0]  sb;
    logic        is_st;
    int          n_st;
    int          wcnt;

    initial begin
        rst = 1'b0; flush = 1'b0;
        st_req = 1'b0; st_addr = '0; st_wdata = '0; st_byte_enable = '0;
        ld_req = 1'b0; ld_addr = '0;
        mem_resp_d = 1'b0; mem_rdata_d = '0;
        step(); step();

        // reset state
        chk("rst_read",  32'(mem_read_d), 0);
        chk("rst_write", 32'(mem_write_d), 0);
        chk("rst_addr",  mem_address_d, 0);
        chk("rst_wdata", mem_wdata_d, 0);
        chk("rst_be",    32'(mem_byte_enable_d), 0);
        chk("rst_st_resp", 32'(st_resp), 0);
        chk("rst_ld_resp", 32'(ld_resp), 0);
        chk("rst_state", 32'(dut.state_q), 32'(IDLE));
        rst = 1'b1;
        step();

        // store alone, cache responds in the third cycle of the request
        st_req = 1'b1; st_addr = 32'h100; st_wdata = 32'hDEADBEEF; st_byte_enable = 4'hF;
        step();
        chk("st_read_low", 32'(mem_read_d), 0);
        wcnt = 0;
        for (int k = 0; k < 3; k++) begin
            if (k == 2) mem_resp_d = 1'b1;
            settle();
            if (mem_write_d) wcnt++;
            chk("st_addr_stable", mem_address_d, 32'h100);
            chk("st_wdata_stable", mem_wdata_d, 32'hDEADBEEF);
            chk("st_be_stable", 32'(mem_byte_enable_d), 32'hF);
            chk("st_resp_pulse", 32'(st_resp), 32'(k == 2));
            step();
        end
        mem_resp_d = 1'b0; st_req = 1'b0;
        settle();
        chk("st_write_cycles", 32'(wcnt), 3);
        chk("st_write_drop", 32'(mem_write_d), 0);
        chk("st_resp_drop", 32'(st_resp), 0);

        // contention: 6 stores vs one waiting load
        st_req = 1'b1; ld_req = 1'b1; ld_addr = 32'h300;
        st_addr = 32'h400; st_wdata = 32'h11110000; st_byte_enable = 4'h3;
        n_st = 0;
        for (int t = 0; t < 7; t++) begin
            step();
            is_st = (t != 4);
            chk("ct_write", 32'(mem_write_d), 32'(is_st));
            chk("ct_read", 32'(mem_read_d), 32'(!is_st));
            chk("ct_addr", mem_address_d, is_st ? st_addr : 32'h300);
            if (t == 3) chk("ct_streak_max", 32'(dut.streak_q), 4);
            if (!is_st) chk("ct_streak_clr", 32'(dut.streak_q), 0);
            mem_resp_d = 1'b1; mem_rdata_d = 32'hCAFE0000 + 32'(t);
            settle();
            chk("ct_st_resp", 32'(st_resp), 32'(is_st));
            chk("ct_ld_resp", 32'(ld_resp), 32'(!is_st));
            if (!is_st) chk("ct_ld_rdata", ld_rdata, 32'hCAFE0000 + 32'(t));
            step();
            mem_resp_d = 1'b0;
            if (is_st) begin
                n_st++;
                st_addr = st_addr + 32'd4;
                if (n_st == 6) st_req = 1'b0;
            end else begin
                ld_req = 1'b0;
            end
        end

        // flush one cycle after a load grant: drain without ld_resp
        ld_req = 1'b1; ld_addr = 32'h200;
        step();
        chk("fl_read", 32'(mem_read_d), 1);
        chk("fl_addr", mem_address_d, 32'h200);
        flush = 1'b1;
        settle();
        chk("fl_ld_resp0", 32'(ld_resp), 0);
        step();
        flush = 1'b0; ld_req = 1'b0;
        chk("fl_state_drain", 32'(dut.state_q), 32'(DRAIN));
        for (int k = 1; k <= 4; k++) begin
            if (k == 2) flush = 1'b1;
            if (k == 4) begin mem_resp_d = 1'b1; mem_rdata_d = 32'h1234; end
            settle();
            chk("fl_read_held", 32'(mem_read_d), 1);
            chk("fl_addr_held", mem_address_d, 32'h200);
            chk("fl_no_ld_resp", 32'(ld_resp), 0);
            step();
            flush = 1'b0;
        end
        mem_resp_d = 1'b0;
        ld_req = 1'b1; ld_addr = 32'h204;
        settle();
        chk("fl_idle_read", 32'(mem_read_d), 0);
        step();
        chk("fl_regrant", 32'(mem_read_d), 1);
        chk("fl_regrant_addr", mem_address_d, 32'h204);
        mem_resp_d = 1'b1; mem_rdata_d = 32'h5555;
        settle();
        chk("fl_next_ld_resp", 32'(ld_resp), 1);
        chk("fl_next_rdata", ld_rdata, 32'h5555);
        step();
        mem_resp_d = 1'b0; ld_req = 1'b0;

        // flush while a store is outstanding and a load waits
        st_req = 1'b1; st_addr = 32'h500; st_wdata = 32'hA5A5A5A5; st_byte_enable = 4'h1;
        step();
        ld_req = 1'b1; ld_addr = 32'h600; flush = 1'b1;
        settle();
        chk("fs_st_resp0", 32'(st_resp), 0);
        step();
        chk("fs_write_held", 32'(mem_write_d), 1);
        mem_resp_d = 1'b1;
        settle();
        chk("fs_st_resp1", 32'(st_resp), 1);
        step();
        mem_resp_d = 1'b0; st_req = 1'b0;
        step();
        chk("fs_no_ld_grant", 32'(mem_read_d), 0);
        chk("fs_no_st_grant", 32'(mem_write_d), 0);
        flush = 1'b0;
        step();
        chk("fs_ld_grant", 32'(mem_read_d), 1);
        chk("fs_ld_addr", mem_address_d, 32'h600);
        mem_resp_d = 1'b1; mem_rdata_d = 32'h77;
        settle();
        chk("fs_ld_resp", 32'(ld_resp), 1);
        step();
        mem_resp_d = 1'b0; ld_req = 1'b0;

        // asynchronous reset in the middle of a load
        ld_req = 1'b1; ld_addr = 32'h700;
        step();
        chk("rl_read", 32'(mem_read_d), 1);
        rst = 1'b0;
        settle();
        chk("rl_read_async", 32'(mem_read_d), 0);
        chk("rl_addr_async", mem_address_d, 0);
        step();
        rst = 1'b1;
        settle();
        chk("rl_read_release", 32'(mem_read_d), 0);
        step();
        chk("rl_regrant", 32'(mem_read_d), 1);
        chk("rl_regrant_addr", mem_address_d, 32'h700);
        mem_resp_d = 1'b1; mem_rdata_d = 32'h99;
        settle();
        chk("rl_ld_resp", 32'(ld_resp), 1);
        step();
        mem_resp_d = 1'b0; ld_req = 1'b0;

        // randomized traffic against the transaction model
        rst = 1'b0;
        step();
        rst = 1'b1;
        act = 0; m_addr = '0; m_wdata = '0; m_be = '0; m_cancel = 1'b0; m_wait = 0; m_streak = 0;
        sp = 1'b0; lp = 1'b0; sa = '0; sd = '0; sb = '0; la = '0;
        step();
        for (int c = 0; c < 3000; c++) begin
            chk("rnd_read", 32'(mem_read_d), 32'(act == 1));
            chk("rnd_write", 32'(mem_write_d), 32'(act == 2));
            if (act != 0) chk("rnd_addr", mem_address_d, m_addr);
            if (act == 2) begin
                chk("rnd_wdata", mem_wdata_d, m_wdata);
                chk("rnd_be", 32'(mem_byte_enable_d), 32'(m_be));
            end
            flush = ($urandom_range(0, 11) == 0);
            if (!sp && $urandom_range(0, 2) == 0) begin
                sp = 1'b1; sa = $urandom; sd = $urandom; sb = 4'($urandom);
            end
            if (!lp && !flush && $urandom_range(0, 2) == 0) begin
                lp = 1'b1; la = $urandom;
            end
            st_req = sp; st_addr = sa; st_wdata = sd; st_byte_enable = sb;
            ld_req = lp; ld_addr = la;
            mem_resp_d = (act != 0) && (m_wait == 0);
            rd = $urandom;
            mem_rdata_d = rd;
            settle();
            chk("rnd_st_resp", 32'(st_resp), 32'((act == 2) && mem_resp_d));
            chk("rnd_ld_resp", 32'(ld_resp), 32'((act == 1) && !m_cancel && mem_resp_d && !flush));
            chk("rnd_ld_rdata", ld_rdata, rd);
            if (act != 0) begin
                if (mem_resp_d) begin
                    if (act == 2) sp = 1'b0;
                    if (act == 1) lp = 1'b0;
                    act = 0;
                end else begin
                    m_wait--;
                    if (act == 1 && flush) m_cancel = 1'b1;
                end
            end else begin
                ld_eff = lp && !flush;
                if (sp && (!ld_eff || m_streak < 4)) begin
                    act = 2; m_addr = sa; m_wdata = sd; m_be = sb;
                    m_streak = ld_eff ? m_streak + 1 : 0;
                end else if (ld_eff) begin
                    act = 1; m_addr = la; m_cancel = 1'b0; m_streak = 0;
                end
                if (act != 0) m_wait = $urandom_range(0, 3);
            end
            if (flush) lp = 1'b0;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
